ascon_perm_scheduler: RTL and testbench

- Round scheduler for the ASCON-128 permutation.
- Owns the 320-bit permutation state register (type_state, 5 x 64-bit words from ascon_pack).
- Sequences pa (12 rounds) or pb (6 rounds) through the external single-round datapath (constant addition -> Ps substitution -> linear layer).
- Drives the per-round constant into that datapath and captures the round result each cycle. Gives the mode FSM a start/done handshake.

---
 rtl/ascon_perm_scheduler_if.sv | 25 ++
 rtl/ascon_perm_scheduler.sv | 64 ++++++
 tb/tb_ascon_perm_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_scheduler_if.sv
// Handshake and state bus between the ASCON round scheduler and its user/datapath.
// The slave side is the scheduler; the master side is the mode FSM plus round datapath.
interface ascon_perm_scheduler_if;
   logic             start_i;
   logic             mode_i;
   logic [4:0][63:0] state_i;
   logic [4:0][63:0] round_result_i;
   logic [4:0][63:0] round_state_o;
   logic [7:0]       round_const_o;
   logic [3:0]       round_idx_o;
   logic             busy_o;
   logic             ready_o;
   logic             done_o;
   logic [4:0][63:0] state_o;

   modport slave (
      input  start_i, mode_i, state_i, round_result_i,
      output round_state_o, round_const_o, round_idx_o, busy_o, ready_o, done_o, state_o
   );

   modport master (
      output start_i, mode_i, state_i, round_result_i,
      input  round_state_o, round_const_o, round_idx_o, busy_o, ready_o, done_o, state_o
   );
endinterface

// File: rtl/ascon_perm_scheduler.sv
// Round scheduler for the ASCON permutation: owns the 320-bit state and steps an
// external single-round datapath through pa or pb, one round per clock.
module ascon_perm_scheduler #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   ascon_perm_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   // pa/pb use the tail of the constant table, so a short run starts part-way in.
   localparam logic [3:0] IDX_A    = 4'(12 - ROUNDS_A);
   localparam logic [3:0] IDX_B    = 4'(12 - ROUNDS_B);
   localparam logic [3:0] IDX_LAST = 4'd11;

   fsm_t             fsm_q;
   fsm_t             fsm_d;
   logic [4:0][63:0] state_q;
   logic [3:0]       idx_q;
   logic             accept;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         idx_q   <= '0;
      end else begin
         fsm_q <= fsm_d;
         if (accept) begin
            state_q <= bus.state_i;
            idx_q   <= bus.mode_i ? IDX_B : IDX_A;
         end else if (fsm_q == RUN) begin
            state_q <= bus.round_result_i;
            if (idx_q != IDX_LAST) begin
               idx_q <= idx_q + 4'd1;
            end
         end
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (bus.start_i) fsm_d = RUN;
         RUN:     if (idx_q == IDX_LAST) fsm_d = DONE;
         DONE:    fsm_d = bus.start_i ? RUN : IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready_o = (fsm_q == IDLE) || (fsm_q == DONE);
      bus.busy_o  = (fsm_q == RUN);
      bus.done_o  = (fsm_q == DONE);
      accept      = bus.ready_o && bus.start_i;
   end

   assign bus.round_state_o = state_q;
   assign bus.state_o       = state_q;
   assign bus.round_idx_o   = idx_q;
   assign bus.round_const_o = {4'hF - idx_q, idx_q};
endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Directed bench for ascon_perm_scheduler: a stub or real ASCON round closes the loop,
// expected constants and final states sit in scoreboard queues until the DUT produces them.
module tb_ascon_perm_scheduler;
   logic clk;
   logic rst;
   logic use_real;

   ascon_perm_scheduler_if bus ();

   ascon_perm_scheduler #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [4:0][63:0] st_t;
   typedef struct {
      st_t st;
      int  cyc;
   } exp_t;

   logic [7:0] const_tbl [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   int   idx_q [$];
   exp_t res_q [$];
   int   checks;
   int   failures;
   int   cyc;
   bit   done_seen;

   function automatic logic [63:0] ror(logic [63:0] x, int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic st_t ascon_round(st_t s, logic [7:0] c);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      st_t r;
      x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      r[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      r[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return r;
   endfunction

   function automatic st_t ref_perm(st_t s, int n);
      st_t r = s;
      for (int i = 12 - n; i < 12; i++) r = ascon_round(r, const_tbl[i]);
      return r;
   endfunction

   always_comb begin
      bus.round_result_i = bus.round_state_o;
      if (use_real) begin
         bus.round_result_i = ascon_round(bus.round_state_o, bus.round_const_o);
      end else begin
         bus.round_result_i[0] = bus.round_state_o[0] + 64'd1;
      end
   end

   task automatic chk(string tag, logic [319:0] obs, logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge and matched to the scoreboard.
   task automatic tick();
      int   ei;
      exp_t er;
      @(posedge clk);
      #1;
      cyc++;
      done_seen = 1'b0;
      if (bus.busy_o === 1'b1) begin
         if (idx_q.size() == 0) begin
            chk("unexpected_busy", 1, 0);
         end else begin
            ei = idx_q.pop_front();
            chk("round_idx", bus.round_idx_o, ei);
            chk("round_const", bus.round_const_o, const_tbl[ei]);
         end
      end
      if (bus.done_o === 1'b1) begin
         done_seen = 1'b1;
         if (res_q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            er = res_q.pop_front();
            chk("final_state", bus.state_o, er.st);
            chk("done_cycle", cyc, er.cyc);
            chk("rounds_consumed", idx_q.size(), 0);
         end
      end
   endtask

   task automatic start_perm(logic mode, st_t s, st_t exp_st);
      int   n;
      exp_t e;
      n = mode ? 6 : 12;
      for (int i = 12 - n; i < 12; i++) idx_q.push_back(i);
      e.st  = exp_st;
      e.cyc = cyc + 1 + n;
      res_q.push_back(e);
      bus.start_i = 1'b1;
      bus.mode_i  = mode;
      bus.state_i = s;
      tick();
      bus.start_i = 1'b0;
      bus.mode_i  = ~mode;
      bus.state_i = ~s;
   endtask

   task automatic wait_done(int budget);
      int k;
      k = 0;
      while (!done_seen && k < budget) begin
         tick();
         k++;
      end
      chk("done_timeout", done_seen, 1);
   endtask

   st_t s0, s1, s2, key_st, ex;

   initial begin
      checks = 0; failures = 0; cyc = 0; done_seen = 1'b0;
      use_real = 1'b0;
      bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.state_i = '0;

      // reset / idle
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_ready", bus.ready_o, 1);
      chk("rst_idx", bus.round_idx_o, 0);
      chk("rst_const", bus.round_const_o, 8'hF0);
      chk("rst_state", bus.state_o, 0);
      tick();
      chk("idle_ready", bus.ready_o, 1);

      // pa with stub: word0 advances once per round
      s0 = '0;
      s0[0] = 64'h80400c0600000000;
      s0[3] = 64'h0123456789abcdef;
      ex = s0; ex[0] = 64'h80400c060000000c;
      start_perm(1'b0, s0, ex);
      chk("run_busy", bus.busy_o, 1);
      chk("run_ready", bus.ready_o, 0);
      wait_done(20);
      chk("done_ready", bus.ready_o, 1);
      tick();
      chk("after_done_pulse", bus.done_o, 0);
      chk("held_state", bus.state_o, ex);

      // pb with stub
      ex = s0; ex[0] = 64'h80400c0600000006;
      start_perm(1'b1, s0, ex);
      wait_done(20);
      tick();

      // start while busy is ignored, then back-to-back start in the DONE cycle
      s1 = '0; s1[0] = 64'h1000; s1[4] = 64'hdeadbeef;
      ex = s1; ex[0] = 64'h100c;
      start_perm(1'b0, s1, ex);
      tick(); tick(); tick();
      bus.start_i = 1'b1; bus.mode_i = 1'b1; bus.state_i = '1;
      tick();
      bus.start_i = 1'b0;
      wait_done(20);
      s2 = '0; s2[0] = 64'h2000; s2[2] = 64'h55;
      ex = s2; ex[0] = 64'h2006;
      start_perm(1'b1, s2, ex);
      chk("b2b_busy", bus.busy_o, 1);
      wait_done(20);
      tick();

      // reset in the middle of a pa run, at idx 5
      start_perm(1'b0, s1, s1);
      for (int i = 0; i < 5; i++) tick();
      chk("pre_abort_idx", bus.round_idx_o, 5);
      idx_q.delete();
      res_q.delete();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_state", bus.state_o, 0);
      chk("abort_done", bus.done_o, 0);
      chk("abort_ready", bus.ready_o, 1);
      for (int i = 0; i < 10; i++) tick();
      ex = s2; ex[0] = 64'h200c;
      start_perm(1'b0, s2, ex);
      wait_done(20);
      tick();

      // real round datapath on an ASCON-128 initialisation state
      use_real = 1'b1;
      key_st = '0;
      key_st[0] = 64'h80400c0600000000;
      key_st[1] = 64'h0001020304050607;
      key_st[2] = 64'h08090a0b0c0d0e0f;
      key_st[3] = 64'h0001020304050607;
      key_st[4] = 64'h08090a0b0c0d0e0f;
      start_perm(1'b0, key_st, ref_perm(key_st, 12));
      wait_done(20);
      tick();
      start_perm(1'b1, key_st, ref_perm(key_st, 6));
      wait_done(20);
      tick();

      chk("queues_drained", idx_q.size() + res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
